mem_access_unit: RTL and testbench

Load/store memory port that sits between the multi-cycle CPU's memory interface and the RAM. It converts a CPU access request (address, func3 width code, write data) into a word-aligned RAM transaction with byte enables, and waits for a variable-latency acknowledge. It returns sign- or zero-extended load data, or a misalignment/fault indication, with a one-cycle completion pulse.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/load_extract.sv | 32 +++
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store memory port.
// Holds the func3 width codes, the controller state encoding, the byte-enable
// width and a helper that maps (func3, addr[1:0]) to byte-lane enables.
package mem_pkg;

  localparam int unsigned BeWidth = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_e;

  // Lane enables for an aligned access; word accesses always use all four lanes.
  function automatic logic [BeWidth-1:0] byte_enable(input logic [2:0] func3,
                                                     input logic [1:0] addr_lo);
    logic [BeWidth-1:0] be;
    case (func3)
      F3_B, F3_BU: be = 4'b0001 << addr_lo;
      F3_H, F3_HU: be = 4'b0011 << addr_lo;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Load data extraction: aligns the addressed byte/halfword of a RAM word to
// bit 0 and sign- or zero-extends it according to func3.
// Ports:
//   rdata   in  32  raw RAM word
//   addr_lo in  2   byte offset within the word
//   func3   in  3   width code (B, H, W, BU, HU)
//   data    out 32  extended load result
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    data = rdata;
    case (func3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h000000, shifted[7:0]};
      F3_HU:   data = {16'h0000, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store port between the CPU memory interface and the RAM.
// Validates a CPU request, issues a word-aligned RAM access with byte enables,
// waits for a variable-latency ack (with timeout) and reports completion.
// Ports:
//   clk, clr                       clock, synchronous active-high reset
//   cpu_req/we/func3/addr/wdata    CPU request, sampled in IDLE only
//   cpu_rdata                      extended load data, held until next load
//   cpu_done/misalign/fault        one-cycle completion pulse and cause
//   cpu_busy                       high in every state except IDLE
//   mem_addr/read/write/be/wdata   registered RAM request, held through ACCESS
//   mem_rdata, mem_ack             RAM response, honoured only in ACCESS
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [2:0]         cpu_func3,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_done,
  output logic               cpu_busy,
  output logic               cpu_misalign,
  output logic               cpu_fault,
  output logic [31:0]        mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BeWidth-1:0] mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ack
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e     state_q;
  logic [7:0] wait_q;
  logic [1:0] addr_lo_q;
  logic [2:0] func3_q;
  logic       we_q;

  logic               req_illegal;
  logic               req_misalign;
  logic [BeWidth-1:0] req_be;
  logic [31:0]        req_wdata;
  logic [31:0]        ld_data;

  load_extract u_load_extract (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .func3   (func3_q),
    .data    (ld_data)
  );

  // Request checks on the raw CPU inputs so the decision lands in the accepting edge.
  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    case (cpu_func3)
      F3_B, F3_H, F3_W: req_illegal = 1'b0;
      F3_BU, F3_HU:     req_illegal = cpu_we;  // unsigned widths are load-only
      default:          req_illegal = 1'b1;
    endcase
    case (cpu_func3)
      F3_H, F3_HU: req_misalign = cpu_addr[0];
      F3_W:        req_misalign = |cpu_addr[1:0];
      default:     req_misalign = 1'b0;
    endcase
    req_be    = byte_enable(cpu_func3, cpu_addr[1:0]);
    req_wdata = cpu_wdata << {cpu_addr[1:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      wait_q       <= 8'd0;
      addr_lo_q    <= 2'b00;
      func3_q      <= 3'b000;
      we_q         <= 1'b0;
      cpu_rdata    <= 32'd0;
      cpu_done     <= 1'b0;
      cpu_busy     <= 1'b0;
      cpu_misalign <= 1'b0;
      cpu_fault    <= 1'b0;
      mem_addr     <= 32'd0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_be       <= '0;
      mem_wdata    <= 32'd0;
    end else begin
      cpu_done     <= 1'b0;
      cpu_misalign <= 1'b0;
      cpu_fault    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_lo_q <= cpu_addr[1:0];
            func3_q   <= cpu_func3;
            we_q      <= cpu_we;
            cpu_busy  <= 1'b1;
            if (req_illegal) begin
              state_q   <= ERR;
              cpu_done  <= 1'b1;
              cpu_fault <= 1'b1;
            end else if (req_misalign) begin
              state_q      <= ERR;
              cpu_done     <= 1'b1;
              cpu_misalign <= 1'b1;
            end else begin
              state_q   <= ACCESS;
              wait_q    <= 8'd0;
              mem_addr  <= {cpu_addr[31:2], 2'b00};
              mem_read  <= ~cpu_we;
              mem_write <= cpu_we;
              mem_be    <= req_be;
              mem_wdata <= req_wdata;
            end
          end
        end
        ACCESS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (mem_ack || (wait_q == MaxWait)) begin
            mem_addr  <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= 32'd0;
            cpu_done  <= 1'b1;
            if (mem_ack) begin
              state_q <= RESP;
              if (!we_q) begin
                cpu_rdata <= ld_data;
              end
            end else begin
              state_q   <= ERR;
              cpu_fault <= 1'b1;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        RESP, ERR: begin
          state_q  <= IDLE;
          cpu_busy <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          cpu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (MAX_WAIT = 4).
// Inputs are driven 1 time unit after each rising edge and outputs are sampled
// there too; "cycle n" means the interval after rising edge n of a request.
module tb_mem_access_unit;

  logic        clk;
  logic        clr;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_func3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        cpu_misalign;
  logic        cpu_fault;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_unit #(
    .MAX_WAIT (4)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_func3    (cpu_func3),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_done     (cpu_done),
    .cpu_busy     (cpu_busy),
    .cpu_misalign (cpu_misalign),
    .cpu_fault    (cpu_fault),
    .mem_addr     (mem_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request in cycle 0, advance to cycle 1 and drop cpu_req.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_func3 = f3;
    cpu_addr  = addr;
    cpu_wdata = wd;
    step();
    cpu_req   = 1'b0;
  endtask

  // Ack in the current cycle and advance to the completion cycle.
  task automatic ack_now(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin
    clr       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_func3 = 3'b000;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    mem_rdata = 32'd0;
    mem_ack   = 1'b0;
    step();
    step();
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_read", {31'd0, mem_read}, 32'd0);
    chk("rst_write", {31'd0, mem_write}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    clr = 1'b0;
    step();

    // LW 0x100, ack in cycle 3.
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0);
    chk("lw_c1_read", {31'd0, mem_read}, 32'd1);
    chk("lw_c1_be", {28'd0, mem_be}, 32'h0000_000F);
    chk("lw_c1_addr", mem_addr, 32'h0000_0100);
    chk("lw_c1_busy", {31'd0, cpu_busy}, 32'd1);
    chk("lw_c1_done", {31'd0, cpu_done}, 32'd0);
    step();
    chk("lw_c2_read", {31'd0, mem_read}, 32'd1);
    step();
    chk("lw_c3_read", {31'd0, mem_read}, 32'd1);
    ack_now(32'hDEAD_BEEF);
    chk("lw_c4_done", {31'd0, cpu_done}, 32'd1);
    chk("lw_c4_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("lw_c4_read", {31'd0, mem_read}, 32'd0);
    chk("lw_c4_busy", {31'd0, cpu_busy}, 32'd1);
    step();
    chk("lw_c5_done", {31'd0, cpu_done}, 32'd0);
    chk("lw_c5_busy", {31'd0, cpu_busy}, 32'd0);

    // LB 0x103, ack in the first ACCESS cycle.
    issue(1'b0, 3'b000, 32'h0000_0103, 32'd0);
    chk("lb_be", {28'd0, mem_be}, 32'h0000_0008);
    ack_now(32'h80FF_0000);
    chk("lb_done", {31'd0, cpu_done}, 32'd1);
    chk("lb_rdata", cpu_rdata, 32'hFFFF_FF80);
    step();

    // LBU 0x103.
    issue(1'b0, 3'b100, 32'h0000_0103, 32'd0);
    ack_now(32'h80FF_0000);
    chk("lbu_rdata", cpu_rdata, 32'h0000_0080);
    step();

    // LH 0x102.
    issue(1'b0, 3'b001, 32'h0000_0102, 32'd0);
    chk("lh_be", {28'd0, mem_be}, 32'h0000_000C);
    ack_now(32'h80FF_0000);
    chk("lh_rdata", cpu_rdata, 32'hFFFF_80FF);
    step();

    // LHU 0x102.
    issue(1'b0, 3'b101, 32'h0000_0102, 32'd0);
    ack_now(32'h80FF_0000);
    chk("lhu_rdata", cpu_rdata, 32'h0000_80FF);
    step();

    // SH 0x1234ABCD at 0x202.
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD);
    chk("sh_write", {31'd0, mem_write}, 32'd1);
    chk("sh_read", {31'd0, mem_read}, 32'd0);
    chk("sh_addr", mem_addr, 32'h0000_0200);
    chk("sh_be", {28'd0, mem_be}, 32'h0000_000C);
    chk("sh_wdata_hi", {16'd0, mem_wdata[31:16]}, 32'h0000_ABCD);
    ack_now(32'h5555_5555);
    chk("sh_done", {31'd0, cpu_done}, 32'd1);
    chk("sh_rdata_kept", cpu_rdata, 32'h0000_80FF);
    chk("sh_write_drop", {31'd0, mem_write}, 32'd0);
    step();

    // SB 0xA5 at 0x301.
    issue(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5);
    chk("sb_be", {28'd0, mem_be}, 32'h0000_0002);
    chk("sb_wdata", mem_wdata, 32'h0000_A500);
    ack_now(32'd0);
    step();

    // LW 0x101: misaligned.
    issue(1'b0, 3'b010, 32'h0000_0101, 32'd0);
    chk("mis_done", {31'd0, cpu_done}, 32'd1);
    chk("mis_flag", {31'd0, cpu_misalign}, 32'd1);
    chk("mis_fault", {31'd0, cpu_fault}, 32'd0);
    chk("mis_read", {31'd0, mem_read}, 32'd0);
    chk("mis_busy", {31'd0, cpu_busy}, 32'd1);
    step();
    chk("mis_c2_done", {31'd0, cpu_done}, 32'd0);
    chk("mis_c2_busy", {31'd0, cpu_busy}, 32'd0);
    chk("mis_c2_read", {31'd0, mem_read}, 32'd0);

    // func3 = 011: illegal.
    issue(1'b0, 3'b011, 32'h0000_0100, 32'd0);
    chk("ill_done", {31'd0, cpu_done}, 32'd1);
    chk("ill_fault", {31'd0, cpu_fault}, 32'd1);
    chk("ill_mis", {31'd0, cpu_misalign}, 32'd0);
    chk("ill_read", {31'd0, mem_read}, 32'd0);
    step();

    // Store with BU: illegal.
    issue(1'b1, 3'b100, 32'h0000_0100, 32'd0);
    chk("sbu_fault", {31'd0, cpu_fault}, 32'd1);
    chk("sbu_write", {31'd0, mem_write}, 32'd0);
    step();

    // Timeout: LW 0x300, no ack; fault in cycle 6.
    issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("to_c%0d_read", c), {31'd0, mem_read}, 32'd1);
      chk($sformatf("to_c%0d_done", c), {31'd0, cpu_done}, 32'd0);
      step();
    end
    chk("to_c6_done", {31'd0, cpu_done}, 32'd1);
    chk("to_c6_fault", {31'd0, cpu_fault}, 32'd1);
    chk("to_c6_read", {31'd0, mem_read}, 32'd0);
    chk("to_c6_rdata", cpu_rdata, 32'h0000_80FF);
    step();
    // Late ack while idle must be ignored.
    ack_now(32'h1111_1111);
    chk("late_done", {31'd0, cpu_done}, 32'd0);
    chk("late_busy", {31'd0, cpu_busy}, 32'd0);
    chk("late_rdata", cpu_rdata, 32'h0000_80FF);
    issue(1'b0, 3'b010, 32'h0000_0104, 32'd0);
    chk("post_to_read", {31'd0, mem_read}, 32'd1);
    ack_now(32'h0BAD_F00D);
    chk("post_to_done", {31'd0, cpu_done}, 32'd1);
    chk("post_to_rdata", cpu_rdata, 32'h0BAD_F00D);
    step();

    // clr during ACCESS.
    issue(1'b0, 3'b010, 32'h0000_0400, 32'd0);
    chk("clr_c1_read", {31'd0, mem_read}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_read", {31'd0, mem_read}, 32'd0);
    chk("clr_busy", {31'd0, cpu_busy}, 32'd0);
    chk("clr_addr", mem_addr, 32'd0);
    chk("clr_rdata", cpu_rdata, 32'd0);
    chk("clr_done", {31'd0, cpu_done}, 32'd0);
    // Request in the first cycle after clr drops: LBU 0x401.
    issue(1'b0, 3'b100, 32'h0000_0401, 32'd0);
    chk("aclr_read", {31'd0, mem_read}, 32'd1);
    chk("aclr_be", {28'd0, mem_be}, 32'h0000_0002);
    ack_now(32'h0000_C300);
    chk("aclr_done", {31'd0, cpu_done}, 32'd1);
    chk("aclr_rdata", cpu_rdata, 32'h0000_00C3);
    step();
    chk("aclr_idle_busy", {31'd0, cpu_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
